data_addr_unit: RTL
===================

Name: data_addr_unit

Overview:
- Parametrised successor to the CPU's data address register.
- Holds the data address, loaded from the datapath, and supports a stride auto-increment with wrap at a programmable limit.
- Adds a burst mode that streams sequential addresses to memory under a valid/ready handshake.
- Also drives the memory address mux, selecting between the PC and the data address.

Parameters:
- AW, 9, address width in bits.
- CW, 4, burst length counter width; maximum burst is 2^CW-1 beats.
- STRIDE, 1, address increment per step; must satisfy 1 <= STRIDE <= LIMIT.
- LIMIT, 2^AW-1, highest legal address; an increment past LIMIT wraps into [0, LIMIT].

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- load_addr  input  1  load data address from datapath_out.
- datapath_out  input  AW  new address value from the datapath.
- inc_addr  input  1  single-step increment of the data address by STRIDE (IDLE only).
- pc_in  input  AW  program counter address.
- addr_sel  input  1  1 = mem_addr shows the data address, 0 = mem_addr shows pc_in.
- burst_start  input  1  begin a burst from the current (or simultaneously loaded) address.
- burst_len  input  CW  number of beats, sampled with burst_start.
- ready  input  1  memory accepts the current beat.
- mem_addr  output  AW  address to memory.
- data_addr_out  output  AW  current data address register.
- valid  output  1  burst beat present on mem_addr.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse when a burst finishes.

Behaviour:
- Reset (async, reset_n=0):
  - data_addr=0, beat count=0, state=IDLE.
  - valid=0, busy=0, done=0.
  - Reset mid-burst aborts the burst immediately; no done pulse is issued.
- States are IDLE, BURST, DONE.
- Increment rule:
  - Compute sum = data_addr + STRIDE in AW+1 bits.
  - next = (sum > LIMIT) ? sum - (LIMIT+1) : sum.
  - No other arithmetic touches data_addr.
- IDLE, priority per cycle:
  - load_addr=1: data_addr <= datapath_out; inc_addr is ignored that cycle.
  - Else if inc_addr=1: data_addr <= next.
  - burst_start=1 with burst_len>0: count <= burst_len, go to BURST.
    - If load_addr is also high, the burst starts from the newly loaded value.
    - An inc_addr in the same cycle still applies, so the burst starts at next.
  - burst_start=1 with burst_len=0: go directly to DONE; zero beats, address unchanged.
- BURST:
  - valid=1, busy=1, mem_addr=data_addr regardless of addr_sel.
  - load_addr, inc_addr and burst_start are ignored.
  - ready=0: hold address and count; valid stays high and mem_addr stays stable.
  - ready=1: data_addr <= next, count <= count-1.
  - If count==1 when ready=1, go to DONE.
  - Latency: a burst of N beats with ready held high takes N cycles in BURST plus 1 cycle in DONE.
- DONE:
  - done=1 for exactly one cycle; valid=0, busy=0.
  - Always returns to IDLE next cycle; inputs are ignored in DONE.
- IDLE and DONE: mem_addr = addr_sel ? data_addr : pc_in (combinational).
- Output timing:
  - data_addr_out = data_addr (registered).
  - valid, busy and done decode directly from the state register, so they are glitch-free and registered-state based.
- Wrap-around applies in both single-step and burst increments.
- After the final beat, data_addr holds the address following the last beat.

Test Plan:
- Reset/load (AW=9): pulse reset_n low mid-cycle -> data_addr_out=0, valid=busy=done=0 asynchronously. Then load_addr=1 with datapath_out=0x1A5 -> data_addr_out=0x1A5 next edge. Hold load_addr=0 -> value held.
- Mux/increment: addr_sel=0 with pc_in=0x010 -> mem_addr=0x010. addr_sel=1 -> mem_addr=data_addr. inc_addr from 0x1FF with LIMIT=0x1FF, STRIDE=1 -> 0x000. With STRIDE=4, LIMIT=0x0FF, increment from 0x0FE -> 0x002.
- Burst, ready held high: load 0x020, burst_start with burst_len=3 -> valid high for 3 cycles with mem_addr 0x020, 0x021, 0x022; then done=1 for one cycle; final data_addr_out=0x023.
- Backpressure: burst_len=2 with ready pattern 0,1,0,0,1 -> mem_addr holds through each stall; exactly 2 beats accepted; done asserts on the cycle after the second accepted beat. load_addr/inc_addr pulses during the burst have no effect.
- Edge cases:
  - burst_len=0 -> done pulses the next cycle with valid never asserted.
  - load_addr and burst_start in the same cycle with datapath_out=0x100 -> first beat at 0x100.
- Reset mid-burst: assert reset_n=0 during beat 2 of 5 -> state IDLE, data_addr=0, no done pulse. After release, a new burst behaves normally.

Source files
------------

// File: rtl/data_addr_unit_if.sv
// data_addr_unit_if -- memory-side burst bus of the data address unit.
//   burst_start / burst_len : burst request from the controller
//   ready                   : memory accepts the current beat
//   mem_addr                : address presented to memory
//   valid / busy / done     : beat present / burst running / burst finished pulse
// master: the address unit; slave: the controller/memory side.
interface data_addr_unit_if #(
  parameter int unsigned AW = 9,
  parameter int unsigned CW = 4
);
  logic          burst_start;
  logic [CW-1:0] burst_len;
  logic          ready;
  logic [AW-1:0] mem_addr;
  logic          valid;
  logic          busy;
  logic          done;

  modport master (
    input  burst_start, burst_len, ready,
    output mem_addr, valid, busy, done
  );

  modport slave (
    output burst_start, burst_len, ready,
    input  mem_addr, valid, busy, done
  );
endinterface

// File: rtl/data_addr_unit.sv
// data_addr_unit -- data address register with stride auto-increment, wrap
// at LIMIT, a handshaked burst mode and the PC/data memory address mux.
//   clk, reset_n   : clock, asynchronous active-low reset
//   load_addr      : load data address from datapath_out
//   datapath_out   : new address value
//   inc_addr       : single-step increment by STRIDE (IDLE only)
//   pc_in          : program counter address
//   addr_sel       : 1 = mem_addr shows data address, 0 = pc_in (outside bursts)
//   bus (master)   : burst_start/burst_len/ready in, mem_addr/valid/busy/done out
//   data_addr_out  : current data address register
module data_addr_unit #(
  parameter int unsigned AW     = 9,
  parameter int unsigned CW     = 4,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned LIMIT  = (1 << AW) - 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load_addr,
  input  logic [AW-1:0]          datapath_out,
  input  logic                   inc_addr,
  input  logic [AW-1:0]          pc_in,
  input  logic                   addr_sel,
  data_addr_unit_if.master       bus,
  output logic [AW-1:0]          data_addr_out
);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_t;

  localparam logic [AW:0] LP_STRIDE = (AW+1)'(STRIDE);
  localparam logic [AW:0] LP_LIMIT  = (AW+1)'(LIMIT);
  localparam logic [AW:0] LP_SPAN   = (AW+1)'(LIMIT + 1);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_cnt;
  logic [AW:0]   w_sum;
  logic [AW:0]   w_wrap;
  logic [AW-1:0] w_next;

  // Increment is done one bit wider so a carry out of AW bits still compares
  // correctly against LIMIT before wrapping.
  assign w_sum  = {1'b0, r_addr} + LP_STRIDE;
  assign w_wrap = w_sum - LP_SPAN;
  assign w_next = (w_sum > LP_LIMIT) ? w_wrap[AW-1:0] : w_sum[AW-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.burst_start)
                 w_state_nxt = (bus.burst_len != '0) ? S_BURST : S_DONE;
      S_BURST: if (bus.ready && r_cnt == CW'(1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr <= '0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Load/increment and burst capture happen together, so a burst
          // starts from the freshly loaded or incremented address.
          if (load_addr)     r_addr <= datapath_out;
          else if (inc_addr) r_addr <= w_next;
          if (bus.burst_start && bus.burst_len != '0) r_cnt <= bus.burst_len;
        end
        S_BURST: begin
          if (bus.ready) begin
            r_addr <= w_next;
            r_cnt  <= r_cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.valid    = (r_state == S_BURST);
    bus.busy     = (r_state == S_BURST);
    bus.done     = (r_state == S_DONE);
    bus.mem_addr = ((r_state == S_BURST) || addr_sel) ? r_addr : pc_in;
  end

  assign data_addr_out = r_addr;

endmodule
